// File: rtl/chain_encoder.sv
// chain_encoder: raster-scans a 64x64 binary image, then traces the outer
// boundary of the first object found (Moore neighbour tracing) and emits
// Freeman chain codes through a valid/ready handshake.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   start             one-cycle pulse, honoured only in IDLE or DONE
//   pix_rd_en         image memory read strobe
//   pix_addr[11:0]    {row[5:0], col[5:0]}
//   pix_data          pixel, valid one cycle after pix_rd_en (1 = object)
//   code[7:0]         Freeman direction 0..7, zero-extended
//   code_valid        code is valid; consumed on code_valid & code_ready
//   code_ready        consumer ready
//   perimeter[8:0]    number of codes emitted
//   area[11:0]        count of 1-pixels (saturating)
//   start_x, start_y  row / col of first 1-pixel in raster order
//   done, error       completion flags; error on empty image or perimeter overflow
module chain_encoder #(
    parameter int MAX_PERIM = 511
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        pix_rd_en,
    output logic [11:0] pix_addr,
    input  logic        pix_data,
    output logic [7:0]  code,
    output logic        code_valid,
    input  logic        code_ready,
    output logic [8:0]  perimeter,
    output logic [11:0] area,
    output logic [5:0]  start_x,
    output logic [5:0]  start_y,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {IDLE, SCAN, TRACE_RD, TRACE_CHK, EMIT, DONE} state_t;

    localparam logic [8:0] PMAX = 9'(MAX_PERIM);

    state_t      state;
    logic [2:0]  d;          // direction of the last move
    logic [2:0]  k;          // direction currently being probed
    logic [2:0]  n;          // probes already done in this search
    logic [5:0]  cur_r, cur_c;
    logic [5:0]  nr, nc;     // neighbour under test
    logic        oob;        // neighbour under test lies outside the image
    logic        chk_vld;    // scan read data is valid this cycle
    logic [11:0] chk_addr;   // address that pix_data belongs to during scan
    logic        found;

    // Search starts just past the backtrack position of the previous move.
    function automatic logic [2:0] first_dir(input logic [2:0] dir);
        return dir[0] ? dir + 3'd6 : dir + 3'd7;
    endfunction

    // Returns {in_range, row, col} of the neighbour of (r,c) in direction dir.
    function automatic logic [12:0] step(input logic [5:0] r, input logic [5:0] c,
                                         input logic [2:0] dir);
        logic [7:0] dr, dc, rr, cc;
        dr = 8'd0;
        dc = 8'd0;
        case (dir)
            3'd0: begin dr = 8'd0;  dc = 8'd1;  end
            3'd1: begin dr = 8'hFF; dc = 8'd1;  end
            3'd2: begin dr = 8'hFF; dc = 8'd0;  end
            3'd3: begin dr = 8'hFF; dc = 8'hFF; end
            3'd4: begin dr = 8'd0;  dc = 8'hFF; end
            3'd5: begin dr = 8'd1;  dc = 8'hFF; end
            3'd6: begin dr = 8'd1;  dc = 8'd0;  end
            3'd7: begin dr = 8'd1;  dc = 8'd1;  end
        endcase
        rr = {2'b00, r} + dr;
        cc = {2'b00, c} + dc;
        // -1 wraps to 0xFF and 64 sets bit 6, so any high bit means out of range
        return {(rr[7:6] == 2'b00) && (cc[7:6] == 2'b00), rr[5:0], cc[5:0]};
    endfunction

    logic        scan_end, found_now, hit, at_start, launch, p_in;
    logic [11:0] start_now;
    logic [5:0]  pr, pc, p_r, p_c;
    logic [2:0]  pk;

    // launch = begin a new probe at (pr,pc) in direction pk
    always_comb begin
        scan_end  = chk_vld && (chk_addr == 12'hFFF);
        found_now = found || (chk_vld && pix_data);
        start_now = found ? {start_x, start_y} : chk_addr;
        hit       = !oob && pix_data;
        at_start  = (cur_r == start_x) && (cur_c == start_y);
        pr        = cur_r;
        pc        = cur_c;
        pk        = k + 3'd1;
        launch    = 1'b0;
        case (state)
            SCAN: begin
                pr     = start_now[11:6];
                pc     = start_now[5:0];
                pk     = first_dir(3'd7);
                launch = scan_end && found_now;
            end
            TRACE_CHK: launch = !hit && (n != 3'd7);
            EMIT: begin
                pk     = first_dir(d);
                launch = code_ready && !at_start;
            end
            default: ;
        endcase
        {p_in, p_r, p_c} = step(pr, pc, pk);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pix_rd_en  <= 1'b0;
            pix_addr   <= '0;
            code       <= '0;
            code_valid <= 1'b0;
            perimeter  <= '0;
            area       <= '0;
            start_x    <= '0;
            start_y    <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            d          <= '0;
            k          <= '0;
            n          <= '0;
            cur_r      <= '0;
            cur_c      <= '0;
            nr         <= '0;
            nc         <= '0;
            oob        <= 1'b0;
            chk_vld    <= 1'b0;
            chk_addr   <= '0;
            found      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= SCAN;
                        area      <= '0;
                        perimeter <= '0;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        start_x   <= '0;
                        start_y   <= '0;
                        found     <= 1'b0;
                        chk_vld   <= 1'b0;
                        pix_rd_en <= 1'b1;
                        pix_addr  <= '0;
                    end
                end
                SCAN: begin
                    // issue side runs one cycle ahead of the check side
                    chk_vld  <= pix_rd_en;
                    chk_addr <= pix_addr;
                    if (pix_rd_en) begin
                        if (pix_addr == 12'hFFF) pix_rd_en <= 1'b0;
                        else                     pix_addr  <= pix_addr + 12'd1;
                    end
                    if (chk_vld && pix_data) begin
                        if (area != 12'hFFF) area <= area + 12'd1;
                        if (!found) begin
                            found   <= 1'b1;
                            start_x <= chk_addr[11:6];
                            start_y <= chk_addr[5:0];
                        end
                    end
                    if (scan_end) begin
                        chk_vld <= 1'b0;
                        d       <= 3'd7;
                        n       <= '0;
                        if (!found_now) begin
                            state <= DONE;
                            done  <= 1'b1;
                            error <= 1'b1;
                        end
                    end
                end
                TRACE_RD: begin
                    pix_rd_en <= 1'b0;
                    state     <= TRACE_CHK;
                end
                TRACE_CHK: begin
                    if (hit) begin
                        n <= '0;
                        if (perimeter == PMAX) begin
                            state <= DONE;
                            done  <= 1'b1;
                            error <= 1'b1;
                        end else begin
                            code       <= {5'd0, k};
                            code_valid <= 1'b1;
                            d          <= k;
                            cur_r      <= nr;
                            cur_c      <= nc;
                            perimeter  <= perimeter + 9'd1;
                            state      <= EMIT;
                        end
                    end else if (n == 3'd7) begin
                        // isolated pixel: nothing to trace
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        n <= n + 3'd1;
                    end
                end
                EMIT: begin
                    if (code_ready) begin
                        code_valid <= 1'b0;
                        if (at_start) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Out-of-range neighbours skip the read and resolve in TRACE_CHK.
            if (launch) begin
                k     <= pk;
                cur_r <= pr;
                cur_c <= pc;
                nr    <= p_r;
                nc    <= p_c;
                oob   <= !p_in;
                if (p_in) begin
                    state     <= TRACE_RD;
                    pix_rd_en <= 1'b1;
                    pix_addr  <= {p_r, p_c};
                end else begin
                    state <= TRACE_CHK;
                end
            end
        end
    end

endmodule

// File: tb/tb_chain_encoder.sv
// Self-checking bench for chain_encoder: behavioural image memory, expected
// chain codes queued per case and compared as the DUT hands them over.
module tb_chain_encoder;

    logic        clk = 1'b0;
    logic        reset, start, pix_rd_en, pix_data, code_valid, code_ready, done, error;
    logic [11:0] pix_addr, area;
    logic [7:0]  code;
    logic [8:0]  perimeter;
    logic [5:0]  start_x, start_y;

    logic        img [4096];
    int          exp_q[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          rd_cnt = 0;
    logic [31:0] mon_exp;

    chain_encoder dut (
        .clk(clk), .reset(reset), .start(start),
        .pix_rd_en(pix_rd_en), .pix_addr(pix_addr), .pix_data(pix_data),
        .code(code), .code_valid(code_valid), .code_ready(code_ready),
        .perimeter(perimeter), .area(area), .start_x(start_x), .start_y(start_y),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    initial pix_data = 1'b0;
    always @(posedge clk) begin
        if (pix_rd_en) pix_data <= img[pix_addr];
        if (pix_rd_en) rd_cnt   <= rd_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // scoreboard pop on every accepted code
    always @(negedge clk) begin
        if (!reset && code_valid && code_ready) begin
            mon_exp = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'hDEAD;
            chk("code", {24'd0, code}, mon_exp);
        end
    end

    task automatic clr_img();
        for (int i = 0; i < 4096; i++) img[i] = 1'b0;
    endtask

    task automatic set_px(input int r, input int c);
        img[r * 64 + c] = 1'b1;
    endtask

    task automatic set_square();
        clr_img();
        set_px(5, 8); set_px(5, 9); set_px(6, 8); set_px(6, 9);
    endtask

    task automatic push_sq();
        exp_q.push_back(6); exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(4);
    endtask

    task automatic wait_vld(input string tag);
        int c = 0;
        while (!code_valid && c < 20000) begin
            @(posedge clk); #1; c++;
        end
        chk(tag, code_valid, 1);
    endtask

    task automatic run_case(input string name, input int e_area, input int e_perim,
                            input int e_sx, input int e_sy, input int e_err,
                            input int e_trace, input bit stall, input int e_cyc);
        int base, cyc, scnt;
        code_ready = !stall;
        base = rd_cnt;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 0;
        scnt = 0;
        while (cyc < 20000) begin
            @(posedge clk); #1; cyc++;
            if (done) break;
            if (stall) begin
                if (code_ready) begin
                    code_ready = 1'b0;
                    scnt = 0;
                end else if (code_valid) begin
                    scnt++;
                    chk({name, "_stall_code"}, {24'd0, code},
                        (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'hDEAD);
                    if (scnt == 5) code_ready = 1'b1;
                end
            end
        end
        chk({name, "_done"}, done, 1);
        if (e_cyc != 0) chk({name, "_latency"}, cyc, e_cyc);
        chk({name, "_area"}, area, e_area);
        chk({name, "_perim"}, perimeter, e_perim);
        chk({name, "_start_x"}, start_x, e_sx);
        chk({name, "_start_y"}, start_y, e_sy);
        chk({name, "_error"}, error, e_err);
        chk({name, "_trace_reads"}, rd_cnt - base - 4096, e_trace);
        chk({name, "_codes_left"}, exp_q.size(), 0);
        chk({name, "_rd_en_idle"}, pix_rd_en, 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        code_ready = 1'b0;
        clr_img();
        repeat (2) @(posedge clk); #1;
        chk("rst_flags", {code_valid, pix_rd_en, done, error}, 0);
        chk("rst_data", {code, pix_addr, perimeter, area, start_x, start_y}, 0);

        // start while in reset must be ignored
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("rst_start_ignored", {pix_rd_en, done}, 0);

        clr_img(); set_px(10, 20);
        run_case("iso", 1, 0, 10, 20, 0, 8, 1'b0, 0);

        set_square(); push_sq();
        run_case("sq", 4, 4, 5, 8, 0, 14, 1'b0, 0);

        clr_img(); set_px(0, 0); set_px(0, 1); set_px(0, 2);
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(4); exp_q.push_back(4);
        run_case("line", 3, 4, 0, 0, 0, 9, 1'b0, 0);

        clr_img();
        run_case("zero", 0, 0, 0, 0, 1, 0, 1'b0, 4097);

        set_square(); push_sq();
        run_case("stall", 4, 4, 5, 8, 0, 14, 1'b1, 0);

        // reset during the second EMIT, then a clean rerun
        set_square(); push_sq();
        code_ready = 1'b0;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_vld("rr_first_vld");
        code_ready = 1'b1;
        @(posedge clk); #1 code_ready = 1'b0;
        wait_vld("rr_second_vld");
        chk("rr_second_code", {24'd0, code}, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rr_flags", {code_valid, pix_rd_en, done, error}, 0);
        chk("rr_data", {code, pix_addr, perimeter, area, start_x, start_y}, 0);
        exp_q.delete();
        reset = 1'b0;
        @(posedge clk); #1;
        push_sq();
        run_case("rerun", 4, 4, 5, 8, 0, 14, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
